// File: rtl/axi_read_arbiter_pkg.sv
// axi_read_arbiter_pkg
//   Shared definitions for the I/D cache read arbiter: FSM state encoding,
//   burst owner encoding, fixed AXI field values and default ARIDs.
package axi_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [3:0] DEFAULT_ID_I = 4'd0;
  localparam logic [3:0] DEFAULT_ID_D = 4'd1;

  // A beat ends the burst either when the slave flags it or when the count
  // says it must be the last one; a missing RLAST must not hang the port.
  function automatic logic beat_is_final(input logic       last,
                                         input logic [7:0] cnt,
                                         input logic [7:0] len);
    return last || (cnt == len);
  endfunction

endpackage

// File: rtl/axi_read_arbiter_rr.sv
// rr_arbiter2
//   Two-requester round-robin grant. Grants are combinational; the
//   last-grant pointer only moves when the caller accepts a grant (take).
//   The pointer resets to I so D wins the first tie.
// Ports:
//   clk, rst      clock, async active-low reset
//   req_i, req_d  request lines
//   take          grant is consumed this cycle
//   gnt_i, gnt_d  one-hot (or zero) grant
module rr_arbiter2
  import axi_read_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic req_d,
  input  logic take,
  output logic gnt_i,
  output logic gnt_d
);

  owner_t last_q;

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (req_i && req_d) begin
      if (last_q == OWN_I) gnt_d = 1'b1;
      else                 gnt_i = 1'b1;
    end else begin
      gnt_i = req_i;
      gnt_d = req_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= OWN_I;
    end else if (take && gnt_d) begin
      last_q <= OWN_D;
    end else if (take && gnt_i) begin
      last_q <= OWN_I;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
//   Merges icache (port I) and dcache (port D) read requests onto one AXI4
//   read channel with a single burst outstanding. Beats are forwarded
//   combinationally to the owning port; beat count, RLAST and RID are
//   checked against the latched request and any mismatch sets a sticky
//   err_proto.
// Ports:
//   clk, rst                           clock, async active-low reset
//   i_ar*/i_r*, d_ar*/d_r*             requester-side AR and R channels
//   arid..arvalid, arready             AXI AR channel toward memory
//   rid..rvalid, rready                AXI R channel from memory
//   err_proto                          sticky protocol error
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no burst; grant a requester and latch its fields
// ADDR    | arvalid high with latched fields, waiting for arready
// DATA    | R channel passed through to the owner until the final beat
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter logic [3:0] ID_I = DEFAULT_ID_I,
  parameter logic [3:0] ID_D = DEFAULT_ID_D
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rvalid,
  input  logic        i_rready,
  output logic        i_rlast,
  output logic        i_rerr,

  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  input  logic        d_rready,
  output logic        d_rlast,
  output logic        d_rerr,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic        err_proto
);

  state_t      state_q, state_d;
  owner_t      owner_q;
  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic [7:0]  cnt_q;
  logic        err_q;

  logic        gnt_i, gnt_d;
  logic        take;
  logic        ar_done;
  logic        xfer;
  logic        final_beat;
  logic        proto_bad;
  logic        own_i_data, own_d_data;
  logic        resp_err;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .req_i (i_arvalid),
    .req_d (d_arvalid),
    .take  (take),
    .gnt_i (gnt_i),
    .gnt_d (gnt_d)
  );

  assign take       = (state_q == ST_IDLE) && (gnt_i || gnt_d);
  assign ar_done    = (state_q == ST_ADDR) && arready;
  assign own_i_data = (state_q == ST_DATA) && (owner_q == OWN_I);
  assign own_d_data = (state_q == ST_DATA) && (owner_q == OWN_D);
  assign xfer       = rvalid && rready;
  assign final_beat = xfer && beat_is_final(rlast, cnt_q, arlen_q);
  assign resp_err   = (rresp != AXI_RESP_OKAY);

  // Early RLAST, missing RLAST at the expected count, or a foreign RID.
  assign proto_bad = xfer && (( rlast && (cnt_q != arlen_q)) ||
                              (!rlast && (cnt_q == arlen_q)) ||
                              (rid != arid_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (take)       state_d = ST_ADDR;
      ST_ADDR: if (arready)    state_d = ST_DATA;
      ST_DATA: if (final_beat) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Request fields are captured at grant; the requester may misbehave after
  // that without affecting the issued burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q  <= OWN_I;
      arid_q   <= 4'd0;
      araddr_q <= 32'd0;
      arlen_q  <= 8'd0;
    end else if (take) begin
      if (gnt_d) begin
        owner_q  <= OWN_D;
        arid_q   <= ID_D;
        araddr_q <= d_araddr;
        arlen_q  <= d_arlen;
      end else begin
        owner_q  <= OWN_I;
        arid_q   <= ID_I;
        araddr_q <= i_araddr;
        arlen_q  <= i_arlen;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'd0;
    end else if (ar_done) begin
      cnt_q <= 8'd0;
    end else if (xfer) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (proto_bad) begin
      err_q <= 1'b1;
    end
  end

  always_comb begin
    arvalid   = (state_q == ST_ADDR);
    i_arready = ar_done && (owner_q == OWN_I);
    d_arready = ar_done && (owner_q == OWN_D);

    rready = 1'b0;
    if (own_i_data) rready = i_rready;
    if (own_d_data) rready = d_rready;

    i_rvalid = own_i_data && rvalid;
    i_rlast  = own_i_data && rlast;
    i_rerr   = own_i_data && resp_err;
    i_rdata  = own_i_data ? rdata : 32'd0;

    d_rvalid = own_d_data && rvalid;
    d_rlast  = own_d_data && rlast;
    d_rerr   = own_d_data && resp_err;
    d_rdata  = own_d_data ? rdata : 32'd0;
  end

  assign arid      = arid_q;
  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arsize    = AXI_SIZE_WORD;
  assign arburst   = AXI_BURST_INCR;
  assign err_proto = err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
`timescale 1ns/1ps
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] i_araddr = '0;
  logic [7:0]  i_arlen = '0;
  logic        i_arvalid = 1'b0;
  logic        i_arready;
  logic [31:0] i_rdata;
  logic        i_rvalid;
  logic        i_rready = 1'b1;
  logic        i_rlast;
  logic        i_rerr;

  logic [31:0] d_araddr = '0;
  logic [7:0]  d_arlen = '0;
  logic        d_arvalid = 1'b0;
  logic        d_arready;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic        d_rready = 1'b1;
  logic        d_rlast;
  logic        d_rerr;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;

  logic [3:0]  rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        err_proto;

  always #5 clk = ~clk;

  axi_read_arbiter #(.ID_I(4'd0), .ID_D(4'd1)) dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rlast(i_rlast), .i_rerr(i_rerr),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rready(d_rready), .d_rlast(d_rlast), .d_rerr(d_rerr),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .err_proto(err_proto)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  logic  exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, arvalid, 1'b0);
    chk({tag, "_rready"}, rready, 1'b0);
    chk({tag, "_i_arready"}, i_arready, 1'b0);
    chk({tag, "_d_arready"}, d_arready, 1'b0);
    chk({tag, "_i_rvalid"}, i_rvalid, 1'b0);
    chk({tag, "_d_rvalid"}, d_rvalid, 1'b0);
    chk({tag, "_i_rlast"}, i_rlast, 1'b0);
    chk({tag, "_i_rerr"}, i_rerr, 1'b0);
    chk({tag, "_err_proto"}, err_proto, 1'b0);
    chk({tag, "_arid"}, arid, 4'd0);
    chk({tag, "_araddr"}, araddr, 32'd0);
    chk({tag, "_arlen"}, arlen, 8'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Acts as AXI slave plus the owning requester for one burst.
  // last_at: beat index carrying RLAST (or the final beat when no_rlast).
  task automatic serve_burst(input logic port, input logic [31:0] addr, input logic [7:0] len,
                             input int exp_wait, input int ar_stall, input int last_at,
                             input int err_at, input int drop_at, input int abort_at,
                             input bit no_rlast, input bit bad_rid);
    logic [3:0] id;
    int         waited;
    bit         seen;
    beat_t      e;
    logic       lv;
    id = port ? 4'd1 : 4'd0;
    waited = 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      waited++;
      if (arvalid) seen = 1;
    end
    chk("ar_seen", seen, 1'b1);
    if (!seen) return;
    chk("ar_latency", waited, exp_wait);
    chk("arid", arid, id);
    chk("araddr", araddr, addr);
    chk("arlen", arlen, len);
    chk("arsize", arsize, 3'b010);
    chk("arburst", arburst, 2'b01);
    chk("own_arready_low", port ? d_arready : i_arready, 1'b0);

    for (int s = 0; s < ar_stall; s++) begin
      @(posedge clk); #1;
      if (port) d_araddr = ~addr; else i_araddr = ~addr;
      @(negedge clk);
      chk("stall_arvalid", arvalid, 1'b1);
      chk("stall_araddr", araddr, addr);
      chk("stall_arlen", arlen, len);
    end

    @(posedge clk); #1 arready = 1'b1;
    @(negedge clk);
    chk("own_arready", port ? d_arready : i_arready, 1'b1);
    chk("other_arready", port ? i_arready : d_arready, 1'b0);
    chk("addr_rready", rready, 1'b0);
    @(posedge clk); #1;
    arready = 1'b0;
    if (port) d_arvalid = 1'b0; else i_arvalid = 1'b0;

    for (int n = 0; n <= last_at; n++) begin
      lv = (n == last_at) && !no_rlast;
      rvalid = 1'b1;
      rdata  = addr + 32'(4 * n);
      rlast  = lv;
      rresp  = (n == err_at) ? 2'b10 : 2'b00;
      rid    = bad_rid ? ~id : id;
      exp_q.push_back('{data: addr + 32'(4 * n), last: lv, err: (n == err_at)});

      if (n == abort_at) begin
        #1 rst = 1'b0;
        #1;
        chk_reset_outputs("rst_midburst");
        exp_q.delete();
        exp_err = 1'b0;
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        return;
      end

      if (n == drop_at) begin
        if (port) d_rready = 1'b0; else i_rready = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk("drop_rready", rready, 1'b0);
          chk("drop_rvalid", port ? d_rvalid : i_rvalid, 1'b1);
          chk("drop_rdata", port ? d_rdata : i_rdata, exp_q[0].data);
          @(posedge clk); #1;
        end
        if (port) d_rready = 1'b1; else i_rready = 1'b1;
      end

      @(negedge clk);
      e = exp_q.pop_front();
      chk("beat_rvalid", port ? d_rvalid : i_rvalid, 1'b1);
      chk("beat_rdata", port ? d_rdata : i_rdata, e.data);
      chk("beat_rlast", port ? d_rlast : i_rlast, e.last);
      chk("beat_rerr", port ? d_rerr : i_rerr, e.err);
      chk("beat_rready", rready, 1'b1);
      chk("other_rvalid", port ? i_rvalid : d_rvalid, 1'b0);
      chk("other_rlast", port ? i_rlast : d_rlast, 1'b0);
      chk("beat_err_proto", err_proto, exp_err);
      if ((lv && n != int'(len)) || (!lv && n == int'(len)) || bad_rid) exp_err = 1'b1;
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;

    @(negedge clk);
    chk("idle_rready", rready, 1'b0);
    chk("idle_arvalid", arvalid, 1'b0);
    chk("idle_err_proto", err_proto, exp_err);
    chk("beats_left", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b0;
    #1;
    chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Single I refill.
    i_araddr = 32'h0000_0040; i_arlen = 8'd15; i_arvalid = 1'b1;
    serve_burst(1'b0, 32'h0000_0040, 8'd15, 2, 0, 15, -1, -1, -1, 0, 0);

    // Tie: D first, I right after D's last beat, next tie goes to D again.
    i_araddr = 32'h0000_0100; i_arlen = 8'd3; i_arvalid = 1'b1;
    d_araddr = 32'h0000_0200; d_arlen = 8'd3; d_arvalid = 1'b1;
    serve_burst(1'b1, 32'h0000_0200, 8'd3, 2, 0, 3, -1, -1, -1, 0, 0);
    serve_burst(1'b0, 32'h0000_0100, 8'd3, 1, 0, 3, -1, -1, -1, 0, 0);
    i_araddr = 32'h0000_0300; i_arlen = 8'd1; i_arvalid = 1'b1;
    d_araddr = 32'h0000_0400; d_arlen = 8'd1; d_arvalid = 1'b1;
    serve_burst(1'b1, 32'h0000_0400, 8'd1, 2, 0, 1, -1, -1, -1, 0, 0);
    serve_burst(1'b0, 32'h0000_0300, 8'd1, 1, 0, 1, -1, -1, -1, 0, 0);

    // Backpressure on AR and R.
    i_araddr = 32'h0000_1000; i_arlen = 8'd7; i_arvalid = 1'b1;
    serve_burst(1'b0, 32'h0000_1000, 8'd7, 2, 2, 7, -1, 4, -1, 0, 0);

    // Early RLAST, then a normal D burst.
    i_araddr = 32'h0000_2000; i_arlen = 8'd15; i_arvalid = 1'b1;
    serve_burst(1'b0, 32'h0000_2000, 8'd15, 2, 0, 7, -1, -1, -1, 0, 0);
    d_araddr = 32'h0000_2100; d_arlen = 8'd3; d_arvalid = 1'b1;
    serve_burst(1'b1, 32'h0000_2100, 8'd3, 2, 0, 3, -1, -1, -1, 0, 0);

    // Error response on beat 3.
    i_araddr = 32'h0000_3000; i_arlen = 8'd7; i_arvalid = 1'b1;
    serve_burst(1'b0, 32'h0000_3000, 8'd7, 2, 0, 7, 3, -1, -1, 0, 0);

    // Reset during beat 5, then a single-beat D read.
    i_araddr = 32'h0000_4000; i_arlen = 8'd15; i_arvalid = 1'b1;
    serve_burst(1'b0, 32'h0000_4000, 8'd15, 2, 0, 15, -1, -1, 5, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    d_araddr = 32'h0000_5000; d_arlen = 8'd0; d_arvalid = 1'b1;
    serve_burst(1'b1, 32'h0000_5000, 8'd0, 2, 0, 0, -1, -1, -1, 0, 0);

    // Foreign RID on a single-beat read.
    d_araddr = 32'h0000_5100; d_arlen = 8'd0; d_arvalid = 1'b1;
    serve_burst(1'b1, 32'h0000_5100, 8'd0, 2, 0, 0, -1, -1, -1, 0, 1);

    // Missing RLAST at the expected count.
    do_reset();
    d_araddr = 32'h0000_6000; d_arlen = 8'd2; d_arvalid = 1'b1;
    serve_burst(1'b1, 32'h0000_6000, 8'd2, 2, 0, 2, -1, -1, -1, 1, 0);
    i_araddr = 32'h0000_7000; i_arlen = 8'd1; i_arvalid = 1'b1;
    serve_burst(1'b0, 32'h0000_7000, 8'd1, 2, 0, 1, -1, -1, -1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
